// File: rtl/shared_mem_resp_pkg.sv
// rtl/shared_mem_resp_pkg.sv - shared types and sizing constants for the shared memory responder
package shared_mem_resp_pkg;

    // Default sizing, also used by the cpu and arbiter blocks that sit on this bus.
    localparam int NUM_CORES = 3;
    localparam int ADDR_W    = 12;
    localparam int DATA_W    = 8;

    // The access down-counter only has to hold the largest wait count (7).
    localparam int CNT_W     = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } mem_state_t;

endpackage

// File: rtl/shared_mem_resp_if.sv
// rtl/shared_mem_resp_if.sv - per-core request/response bus into the shared memory responder
// Ports (all unpacked per core unless noted):
//   gnt_arb   arbiter grant, one-hot or zero
//   bus_valid core presents a transaction
//   bus_we    1 = write, 0 = read
//   bus_addr  byte address
//   bus_wdata write data
//   bus_ack   one-cycle completion pulse back to the owning core
//   bus_rdata shared response data (single vector)
interface shared_mem_resp_if #(
    parameter int NUM_CORES = shared_mem_resp_pkg::NUM_CORES,
    parameter int ADDR_W    = shared_mem_resp_pkg::ADDR_W,
    parameter int DATA_W    = shared_mem_resp_pkg::DATA_W
);

    logic              gnt_arb   [NUM_CORES];
    logic              bus_valid [NUM_CORES];
    logic              bus_we    [NUM_CORES];
    logic [ADDR_W-1:0] bus_addr  [NUM_CORES];
    logic [DATA_W-1:0] bus_wdata [NUM_CORES];
    logic              bus_ack   [NUM_CORES];
    logic [DATA_W-1:0] bus_rdata;

    // Cores plus arbiter drive the request side.
    modport master (
        output gnt_arb, bus_valid, bus_we, bus_addr, bus_wdata,
        input  bus_ack, bus_rdata
    );

    // The memory responder.
    modport slave (
        input  gnt_arb, bus_valid, bus_we, bus_addr, bus_wdata,
        output bus_ack, bus_rdata
    );

endinterface

// File: rtl/shared_mem_resp_mem_array.sv
// rtl/shared_mem_resp_mem_array.sv - synchronous single-port RAM, one-cycle read latency
// Ports:
//   clk      rising-edge clock
//   i_en     access enable for this cycle
//   i_we     1 = write i_wdata, 0 = read into o_rdata
//   i_addr   byte address covering the whole array
//   i_wdata  write data
//   o_rdata  read data, valid the cycle after a read and held until the next read
module shared_mem_resp_mem_array #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    // Contents are deliberately never reset.
    logic [DATA_W-1:0] r_mem [0:(1 << ADDR_W)-1];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/shared_mem_resp.sv
// rtl/shared_mem_resp.sv - shared memory responder: accepts one granted core, accesses the array, acks
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   bus        slave side of shared_mem_resp_if (grants, requests, acks, read data)
//   busy       high whenever a transaction is in flight (not IDLE)
//   grant_err  one-cycle pulse when more than one grant is seen in IDLE
module shared_mem_resp
    import shared_mem_resp_pkg::*;
#(
    parameter int NUM_CORES   = shared_mem_resp_pkg::NUM_CORES,
    parameter int ADDR_W      = shared_mem_resp_pkg::ADDR_W,
    parameter int DATA_W      = shared_mem_resp_pkg::DATA_W,
    parameter int WAIT_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    shared_mem_resp_if.slave bus,
    output logic             busy,
    output logic             grant_err
);

    localparam int IDX_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int GCNT_W = $clog2(NUM_CORES + 1);

    mem_state_t        r_state;
    mem_state_t        w_next_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_core;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata_hold;

    logic [GCNT_W-1:0] w_gnt_cnt;
    logic [IDX_W-1:0]  w_gnt_idx;
    logic              w_accept;
    logic              w_first_access;
    logic              w_mem_en;
    logic              w_mem_we;
    logic [DATA_W-1:0] w_mem_rdata;
    logic [DATA_W-1:0] w_resp_data;

    // Grant decode: count the grant bits and remember which one is set, so a
    // single grant can be told apart from a multi-grant collision.
    always_comb begin
        w_gnt_cnt = '0;
        w_gnt_idx = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (bus.gnt_arb[i]) begin
                w_gnt_cnt = w_gnt_cnt + GCNT_W'(1);
                w_gnt_idx = IDX_W'(i);
            end
        end
        w_accept = (r_state == IDLE) && (w_gnt_cnt == GCNT_W'(1)) && bus.bus_valid[w_gnt_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_cnt <= CNT_W'(WAIT_CYCLES);
            end else if ((r_state == ACCESS) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    // Transaction latch; only loaded on acceptance, so later bus activity
    // cannot disturb the transaction in flight.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_core  <= w_gnt_idx;
            r_we    <= bus.bus_we[w_gnt_idx];
            r_addr  <= bus.bus_addr[w_gnt_idx];
            r_wdata <= bus.bus_wdata[w_gnt_idx];
        end
    end

    // Keeps bus_rdata stable after the ack pulse has gone.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata_hold <= '0;
        end else if (r_state == RESP) begin
            r_rdata_hold <= w_resp_data;
        end
    end

    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        grant_err    = 1'b0;
        // The counter still holds its load value only in the first ACCESS cycle.
        w_first_access = (r_state == ACCESS) && (r_cnt == CNT_W'(WAIT_CYCLES));
        // Reset in the first ACCESS cycle stops the write before it commits.
        w_mem_en       = w_first_access && !rst;
        w_mem_we       = w_mem_en && r_we;
        w_resp_data    = r_we ? r_wdata : w_mem_rdata;
        bus.bus_rdata  = r_rdata_hold;
        for (int i = 0; i < NUM_CORES; i++) begin
            bus.bus_ack[i] = 1'b0;
        end

        case (r_state)
            IDLE: begin
                grant_err = (w_gnt_cnt > GCNT_W'(1)) && !rst;
                if (w_accept) begin
                    w_next_state = ACCESS;
                end
            end
            ACCESS: begin
                busy = !rst;
                if (r_cnt == '0) begin
                    w_next_state = RESP;
                end
            end
            RESP: begin
                busy          = !rst;
                w_next_state  = IDLE;
                bus.bus_rdata = w_resp_data;
                // Read data comes straight from the RAM output register here,
                // which is what lets WAIT_CYCLES = 0 still meet the ack cycle.
                for (int i = 0; i < NUM_CORES; i++) begin
                    bus.bus_ack[i] = !rst && (r_core == IDX_W'(i));
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase

        if (rst) begin
            bus.bus_rdata = '0;
        end
    end

    shared_mem_resp_mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem_array (
        .clk     (clk),
        .i_en    (w_mem_en),
        .i_we    (w_mem_we),
        .i_addr  (r_addr),
        .i_wdata (r_wdata),
        .o_rdata (w_mem_rdata)
    );

endmodule

// File: tb/tb_shared_mem_resp.sv
// tb/tb_shared_mem_resp.sv - randomized self-checking bench, three WAIT_CYCLES instances in lockstep
module tb_shared_mem_resp;

    localparam int NC  = 3;
    localparam int AW  = 12;
    localparam int DW  = 8;
    localparam int WIN = 11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          g     [NC];
    logic          v     [NC];
    logic          we    [NC];
    logic [AW-1:0] addr  [NC];
    logic [DW-1:0] wd    [NC];

    logic [NC-1:0] ack   [3];
    logic [DW-1:0] rdata [3];
    logic [2:0]    busy_v;
    logic [2:0]    gerr_v;

    shared_mem_resp_if #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW)) if_w0 ();
    shared_mem_resp_if #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW)) if_w1 ();
    shared_mem_resp_if #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW)) if_w7 ();

    for (genvar k = 0; k < NC; k++) begin : g_drv
        assign if_w0.gnt_arb[k]   = g[k];
        assign if_w0.bus_valid[k] = v[k];
        assign if_w0.bus_we[k]    = we[k];
        assign if_w0.bus_addr[k]  = addr[k];
        assign if_w0.bus_wdata[k] = wd[k];
        assign if_w1.gnt_arb[k]   = g[k];
        assign if_w1.bus_valid[k] = v[k];
        assign if_w1.bus_we[k]    = we[k];
        assign if_w1.bus_addr[k]  = addr[k];
        assign if_w1.bus_wdata[k] = wd[k];
        assign if_w7.gnt_arb[k]   = g[k];
        assign if_w7.bus_valid[k] = v[k];
        assign if_w7.bus_we[k]    = we[k];
        assign if_w7.bus_addr[k]  = addr[k];
        assign if_w7.bus_wdata[k] = wd[k];
    end

    assign ack[0]   = {if_w0.bus_ack[2], if_w0.bus_ack[1], if_w0.bus_ack[0]};
    assign ack[1]   = {if_w1.bus_ack[2], if_w1.bus_ack[1], if_w1.bus_ack[0]};
    assign ack[2]   = {if_w7.bus_ack[2], if_w7.bus_ack[1], if_w7.bus_ack[0]};
    assign rdata[0] = if_w0.bus_rdata;
    assign rdata[1] = if_w1.bus_rdata;
    assign rdata[2] = if_w7.bus_rdata;

    shared_mem_resp #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .rst(rst), .bus(if_w0), .busy(busy_v[0]), .grant_err(gerr_v[0]));
    shared_mem_resp #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(1)) u_dut_w1 (
        .clk(clk), .rst(rst), .bus(if_w1), .busy(busy_v[1]), .grant_err(gerr_v[1]));
    shared_mem_resp #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(7)) u_dut_w7 (
        .clk(clk), .rst(rst), .bus(if_w7), .busy(busy_v[2]), .grant_err(gerr_v[2]));

    // Reference model: the byte array as seen by completed writes.
    logic [DW-1:0] model [int];
    logic [AW-1:0] written [$];

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int wait_of(input int j);
        return (j == 0) ? 0 : ((j == 1) ? 1 : 7);
    endfunction

    task automatic clear_inputs();
        for (int i = 0; i < NC; i++) begin
            g[i] = 1'b0; v[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wd[i] = '0;
        end
    endtask

    // One transaction presented for cycle 0 only; observes cycles 0..WIN on all three instances.
    task automatic run_txn(input string tag, input logic [NC-1:0] gm, input logic [NC-1:0] vm,
                           input int core, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input bit exp_acc, input bit scramble, input bit rst_c1);
        int            ack_cyc  [3];
        int            ack_n    [3];
        int            gerr_n   [3];
        int            busy_n   [3];
        logic [NC-1:0] ack_mask [3];
        logic [DW-1:0] ack_data [3];
        logic [DW-1:0] exp_d;
        int            w;
        exp_d = d;
        if (!wr) exp_d = model.exists(a) ? model[a] : '0;
        for (int j = 0; j < 3; j++) begin
            ack_cyc[j] = -1; ack_n[j] = 0; gerr_n[j] = 0; busy_n[j] = 0;
            ack_mask[j] = '0; ack_data[j] = '0;
        end
        @(posedge clk); #1;
        for (int i = 0; i < NC; i++) begin
            g[i]    = gm[i];
            v[i]    = vm[i];
            we[i]   = (i == core) ? wr : 1'($urandom);
            addr[i] = (i == core) ? a : AW'($urandom);
            wd[i]   = (i == core) ? d : DW'($urandom);
        end
        for (int n = 0; n <= WIN; n++) begin
            if (n > 0) begin
                @(posedge clk); #1;
                if (n == 1) begin
                    if (scramble) begin
                        for (int i = 0; i < NC; i++) begin
                            g[i] = 1'($urandom); v[i] = 1'b1; we[i] = 1'($urandom);
                            addr[i] = AW'($urandom); wd[i] = DW'($urandom);
                        end
                    end else begin
                        clear_inputs();
                    end
                    rst = rst_c1;
                end
                if (n == 2) begin
                    clear_inputs();
                    rst = 1'b0;
                end
            end
            @(negedge clk);
            for (int j = 0; j < 3; j++) begin
                if (ack[j] != '0) begin
                    if (ack_n[j] == 0) begin
                        ack_cyc[j] = n; ack_mask[j] = ack[j]; ack_data[j] = rdata[j];
                    end
                    ack_n[j]++;
                end
                if (gerr_v[j]) gerr_n[j]++;
                if (busy_v[j]) busy_n[j]++;
                if (rst_c1 && n == 2)
                    check_eq($sformatf("%s_w%0d_busy_after_rst", tag, wait_of(j)), 32'(busy_v[j]), 0);
            end
        end
        for (int j = 0; j < 3; j++) begin
            w = wait_of(j);
            check_eq($sformatf("%s_w%0d_ack_count", tag, w), ack_n[j], exp_acc ? 1 : 0);
            check_eq($sformatf("%s_w%0d_grant_err", tag, w), gerr_n[j], ($countones(gm) > 1) ? 1 : 0);
            if (exp_acc) begin
                check_eq($sformatf("%s_w%0d_ack_cycle", tag, w), ack_cyc[j], w + 2);
                check_eq($sformatf("%s_w%0d_ack_core", tag, w), 32'(ack_mask[j]), 1 << core);
                check_eq($sformatf("%s_w%0d_rdata", tag, w), 32'(ack_data[j]), 32'(exp_d));
                check_eq($sformatf("%s_w%0d_rdata_hold", tag, w), 32'(rdata[j]), 32'(exp_d));
                check_eq($sformatf("%s_w%0d_busy_cycles", tag, w), busy_n[j], w + 2);
            end else if (!rst_c1) begin
                check_eq($sformatf("%s_w%0d_busy_cycles", tag, w), busy_n[j], 0);
            end
        end
        if (exp_acc && wr) begin
            model[a] = d;
            written.push_back(a);
        end
    endtask

    // Grant and valid held for cycles 0..len-1; each instance re-accepts every WAIT_CYCLES+3 cycles.
    task automatic run_b2b(input int core, input logic [AW-1:0] a, input int len);
        int acks [3][$];
        int w;
        int exp_n;
        @(posedge clk); #1;
        clear_inputs();
        g[core] = 1'b1; v[core] = 1'b1; we[core] = 1'b0; addr[core] = a;
        for (int n = 0; n <= len + 12; n++) begin
            if (n > 0) begin
                @(posedge clk); #1;
                if (n == len) clear_inputs();
            end
            @(negedge clk);
            for (int j = 0; j < 3; j++) begin
                if (ack[j] != '0) begin
                    acks[j].push_back(n);
                    check_eq($sformatf("b2b_w%0d_core", wait_of(j)), 32'(ack[j]), 1 << core);
                    check_eq($sformatf("b2b_w%0d_rdata", wait_of(j)), 32'(rdata[j]), 32'(model[a]));
                end
            end
        end
        for (int j = 0; j < 3; j++) begin
            w = wait_of(j);
            exp_n = (len - 1) / (w + 3) + 1;
            check_eq($sformatf("b2b_w%0d_count", w), acks[j].size(), exp_n);
            for (int k = 0; k < acks[j].size() && k < exp_n; k++)
                check_eq($sformatf("b2b_w%0d_ack%0d_cycle", w, k), acks[j][k], k * (w + 3) + w + 2);
        end
    endtask

    initial begin
        logic [AW-1:0] ra;
        logic [DW-1:0] rd;
        int            rc;
        bit            rw;
        clear_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int j = 0; j < 3; j++) begin
            check_eq($sformatf("reset_w%0d_busy", wait_of(j)), 32'(busy_v[j]), 0);
            check_eq($sformatf("reset_w%0d_grant_err", wait_of(j)), 32'(gerr_v[j]), 0);
            check_eq($sformatf("reset_w%0d_ack", wait_of(j)), 32'(ack[j]), 0);
            check_eq($sformatf("reset_w%0d_rdata", wait_of(j)), 32'(rdata[j]), 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // Write then read on core 0.
        run_txn("wr_0a5", 3'b001, 3'b001, 0, 1'b1, 12'h0A5, 8'h3C, 1'b1, 1'b0, 1'b0);
        run_txn("rd_0a5", 3'b001, 3'b001, 0, 1'b0, 12'h0A5, 8'h00, 1'b1, 1'b0, 1'b0);

        // Core 2 granted while core 0 asserts valid without a grant.
        run_txn("wr_fff", 3'b100, 3'b101, 2, 1'b1, 12'hFFF, 8'hA1, 1'b1, 1'b0, 1'b0);
        run_txn("rd_fff", 3'b100, 3'b100, 2, 1'b0, 12'hFFF, 8'h00, 1'b1, 1'b0, 1'b0);
        run_txn("nogrant", 3'b000, 3'b001, 0, 1'b1, 12'h0A5, 8'h77, 1'b0, 1'b0, 1'b0);

        // Two grants at once: nothing accepted, array untouched.
        run_txn("multi_gnt", 3'b011, 3'b011, 0, 1'b1, 12'h0A5, 8'hEE, 1'b0, 1'b0, 1'b0);
        run_txn("rd_after_multi", 3'b001, 3'b001, 0, 1'b0, 12'h0A5, 8'h00, 1'b1, 1'b0, 1'b0);

        // Bus churn during ACCESS must not disturb the write in flight or its neighbours.
        run_txn("wr_00f", 3'b001, 3'b001, 0, 1'b1, 12'h00F, 8'h11, 1'b1, 1'b0, 1'b0);
        run_txn("wr_011", 3'b001, 3'b001, 0, 1'b1, 12'h011, 8'h22, 1'b1, 1'b0, 1'b0);
        run_txn("wr_010_churn", 3'b010, 3'b010, 1, 1'b1, 12'h010, 8'h55, 1'b1, 1'b1, 1'b0);
        run_txn("rd_010", 3'b001, 3'b001, 0, 1'b0, 12'h010, 8'h00, 1'b1, 1'b0, 1'b0);
        run_txn("rd_00f", 3'b010, 3'b010, 1, 1'b0, 12'h00F, 8'h00, 1'b1, 1'b0, 1'b0);
        run_txn("rd_011", 3'b100, 3'b100, 2, 1'b0, 12'h011, 8'h00, 1'b1, 1'b0, 1'b0);

        // Reset in cycle 1 of a read aborts it; the next transaction is normal.
        run_txn("rd_rst_abort", 3'b001, 3'b001, 0, 1'b0, 12'h0A5, 8'h00, 1'b0, 1'b0, 1'b1);
        run_txn("rd_after_rst", 3'b001, 3'b001, 0, 1'b0, 12'h0A5, 8'h00, 1'b1, 1'b0, 1'b0);

        // Randomized traffic against the model.
        for (int t = 0; t < 24; t++) begin
            rc = $urandom_range(0, NC - 1);
            rw = ($urandom_range(0, 1) == 1);
            if (rw) begin
                ra = AW'($urandom);
                rd = DW'($urandom);
            end else begin
                ra = written[$urandom_range(0, written.size() - 1)];
                rd = '0;
            end
            if ((t % 6) == 5)
                run_txn($sformatf("rand%0d_idle", t), 3'b000, 3'($urandom), rc, rw, ra, rd, 1'b0, 1'b0, 1'b0);
            else
                run_txn($sformatf("rand%0d", t), 3'(1 << rc), 3'(1 << rc) | 3'($urandom), rc, rw, ra, rd,
                        1'b1, ($urandom_range(0, 3) == 0), 1'b0);
        end

        run_b2b(1, 12'hFFF, 30);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
